rom_fetch_ctrl: RTL

Instruction-fetch controller that sequences the asynchronous instruction ROM for the RISC-V core. It owns the PC, drives the ROM read enable and word address, and captures the returned word into a registered output stage. The output stage talks to decode through a valid/ready handshake. It also handles branch/jump redirects from execute and flags fetch faults. It sits between the ROM and the decode stage.

---
 rtl/rom_fetch_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the asynchronous ROM and
// registers each fetched word into a valid/ready output stage towards decode.
// Latency: a word addressed in cycle N is on the outputs from cycle N+1; 1 word/cycle sustained.
// Backpressure: while OUT_VALID && !OUT_READY the output is held and the PC does not advance.
module rom_fetch_ctrl #(
  parameter int          TAM_POSICIONES = 1024,
  parameter int          TAM_PALABRA    = 32,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  localparam int         ADDR_W         = $clog2(TAM_POSICIONES)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   FETCH_EN,
  input  logic                   REDIRECT_EN,
  input  logic [31:0]            REDIRECT_PC,
  input  logic                   OUT_READY,
  output logic                   OUT_VALID,
  output logic [TAM_PALABRA-1:0] OUT_INSTR,
  output logic [31:0]            OUT_PC,
  output logic                   ROM_READ_EN,
  output logic [ADDR_W-1:0]      ROM_ADDR,
  input  logic [TAM_PALABRA-1:0] ROM_DATA,
  output logic                   FETCH_ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ERROR = 2'd2
  } state_t;

  // First byte address past the end of the ROM; 33 bits so it never wraps.
  localparam logic [32:0] PC_LIMIT = 33'(4 * TAM_POSICIONES);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [31:0]            r_pc;
  logic                   r_out_valid;
  logic [TAM_PALABRA-1:0] r_out_instr;
  logic [31:0]            r_out_pc;
  logic                   r_fetch_err;

  logic w_in_range;
  logic w_misaligned;
  logic w_range_fault;
  logic w_fault;
  logic w_load;

  assign w_in_range    = ({1'b0, r_pc} < PC_LIMIT);
  assign w_misaligned  = REDIRECT_EN && (REDIRECT_PC[1:0] != 2'b00);
  assign w_range_fault = (r_state == FETCH) && FETCH_EN && !w_in_range;
  assign w_fault       = (r_state != ERROR) && (w_misaligned || w_range_fault);
  // A redirect always wins over a fetch; the output slot must be free or draining.
  assign w_load        = (r_state == FETCH) && FETCH_EN && !REDIRECT_EN && w_in_range &&
                         (!r_out_valid || OUT_READY);

  assign ROM_ADDR    = r_pc[ADDR_W+1:2];
  assign ROM_READ_EN = w_load;
  assign OUT_VALID   = r_out_valid;
  assign OUT_INSTR   = r_out_instr;
  assign OUT_PC      = r_out_pc;
  assign FETCH_ERR   = r_fetch_err;

  // State register; ERROR is left only through reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: faults dominate, otherwise FETCH_EN selects IDLE/FETCH.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ERROR) begin
      w_state_nxt = ERROR;
    end else if (w_fault) begin
      w_state_nxt = ERROR;
    end else if (FETCH_EN) begin
      w_state_nxt = FETCH;
    end else begin
      w_state_nxt = IDLE;
    end
  end

  // PC, output stage and sticky fault flag; redirect outranks load and handshake.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_fetch_err <= 1'b0;
    end else if (r_state == ERROR) begin
      r_out_valid <= 1'b0;
    end else if (w_fault) begin
      r_fetch_err <= 1'b1;
      r_out_valid <= 1'b0;
      // A misaligned target is kept for inspection; a range fault freezes the PC.
      if (w_misaligned) r_pc <= REDIRECT_PC;
    end else if (REDIRECT_EN) begin
      r_out_valid <= 1'b0;
      r_pc        <= REDIRECT_PC;
    end else if (w_load) begin
      r_out_instr <= ROM_DATA;
      r_out_pc    <= r_pc;
      r_out_valid <= 1'b1;
      r_pc        <= r_pc + 32'd4;
    end else if (r_out_valid && OUT_READY) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
